mmu_addr_trans: RTL and testbench

Address-translation sequencer placed directly upstream of the 1-stage TLB lookup and directly downstream of its response. It accepts a virtual-address request and drives the lookup address. It then consumes the registered `tlb_s_resp_t` and resolves the final physical address, MAT and exception code. Translation is done by direct-address mode, DMW window or TLB result. The block replays lookups made stale by TLB writes.

---
 rtl/mmu_addr_trans.sv | 250 +++++++++++++++++++++++++
 tb/tb_mmu_addr_trans.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_addr_trans.sv
// mmu_addr_trans: address-translation sequencer that sits around a 1-stage TLB lookup.
//
// Accepts a virtual-address request and drives it to the TLB lookup port. One cycle later
// it consumes the TLB search response and resolves the physical address, memory-access type
// (MAT) and exception code. The address is translated by direct-address mode, by a DMW
// window, or by the TLB result, in that order of priority. A TLB write that lands while a
// lookup is in flight makes that lookup stale, so the block replays it.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o    request handshake
//   req_vaddr_i[31:0]      virtual address
//   req_type_i[1:0]        0 fetch, 1 load, 2 store, 3 treated as load
//   lookup_vaddr_o[31:0]   address driven to the TLB lookup (result returns next cycle)
//   tlb_s_resp_i           packed TLB search response, MSB first:
//                            {found, index[IDX_W-1:0], ps[5:0],
//                             ppn[PPN_W-1:0], plv[1:0], mat[1:0], d, v}
//   tlb_update_i           a TLB entry is being written this cycle
//   flush_i                kill all in-flight work
//   csr_da_i, csr_plv_i, csr_datf_i, csr_datm_i   CRMD fields
//   csr_dmw0_i, csr_dmw1_i raw DMW registers: [0] plv0, [3] plv3, [5:4] mat,
//                          [27:25] pseg, [31:29] vseg
//   resp_valid_o/ready_i   response handshake
//   resp_paddr_o, resp_mat_o, resp_ecode_o, resp_tlb_index_o   translation result
//                          ecode: 0 none, 1 TLBR, 2 PIF, 3 PIL, 4 PIS, 5 PPI, 6 PME
//   replay_cnt_o[7:0]      saturating count of replays
//
// PPN_W must be at least 20: the physical address is 32 bits and pages are at least 4 KiB.

module mmu_addr_trans #(
  parameter int unsigned PPN_W         = 20,
  parameter int unsigned TLB_ENTRY_NUM = 32,
  localparam int unsigned IDX_W        = $clog2(TLB_ENTRY_NUM),
  localparam int unsigned RESP_W       = 1 + IDX_W + 6 + PPN_W + 6
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_vaddr_i,
  input  logic [1:0]        req_type_i,

  output logic [31:0]       lookup_vaddr_o,
  input  logic [RESP_W-1:0] tlb_s_resp_i,
  input  logic              tlb_update_i,
  input  logic              flush_i,

  input  logic              csr_da_i,
  input  logic [1:0]        csr_plv_i,
  input  logic [1:0]        csr_datf_i,
  input  logic [1:0]        csr_datm_i,
  input  logic [31:0]       csr_dmw0_i,
  input  logic [31:0]       csr_dmw1_i,

  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_paddr_o,
  output logic [1:0]        resp_mat_o,
  output logic [2:0]        resp_ecode_o,
  output logic [IDX_W-1:0]  resp_tlb_index_o,
  output logic [7:0]        replay_cnt_o
);

  localparam logic [2:0] EcNone = 3'd0;
  localparam logic [2:0] EcTlbr = 3'd1;
  localparam logic [2:0] EcPif  = 3'd2;
  localparam logic [2:0] EcPil  = 3'd3;
  localparam logic [2:0] EcPis  = 3'd4;
  localparam logic [2:0] EcPpi  = 3'd5;
  localparam logic [2:0] EcPme  = 3'd6;

  localparam logic [1:0] TypeFetch = 2'd0;
  localparam logic [1:0] TypeStore = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StOut   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------
  state_e             r_state;
  state_e             w_state_nxt;
  logic [31:0]        r_vaddr;
  logic [1:0]         r_type;
  logic [31:0]        r_paddr;
  logic [1:0]         r_mat;
  logic [2:0]         r_ecode;
  logic [IDX_W-1:0]   r_index;
  logic [7:0]         r_replay_cnt;

  // ---------------------------------------------------------------------------------------
  // TLB response unpack
  // ---------------------------------------------------------------------------------------
  logic               w_tlb_found;
  logic [IDX_W-1:0]   w_tlb_index;
  logic [5:0]         w_tlb_ps;
  logic [PPN_W-1:0]   w_tlb_ppn;
  logic [1:0]         w_tlb_plv;
  logic [1:0]         w_tlb_mat;
  logic               w_tlb_d;
  logic               w_tlb_v;

  assign {w_tlb_found, w_tlb_index, w_tlb_ps, w_tlb_ppn,
          w_tlb_plv, w_tlb_mat, w_tlb_d, w_tlb_v} = tlb_s_resp_i;

  // ---------------------------------------------------------------------------------------
  // Handshake and control
  // ---------------------------------------------------------------------------------------
  logic w_accept;
  logic w_in_flight;
  logic w_replay;
  logic w_capture;

  // A flush cycle never accepts, so a request offered alongside a flush is simply not taken.
  assign req_ready_o  = !flush_i && ((r_state == StIdle) || ((r_state == StOut) && resp_ready_i));
  assign w_accept     = req_valid_i && req_ready_o;
  assign w_in_flight  = (r_state == StIssue) || (r_state == StWait);
  assign w_replay     = w_in_flight && tlb_update_i && !flush_i;
  // A replayed WAIT cycle holds a stale TLB result, so nothing is captured from it.
  assign w_capture    = (r_state == StWait) && !tlb_update_i && !flush_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = StIssue;
      end
      StIssue: begin
        w_state_nxt = tlb_update_i ? StIssue : StWait;
      end
      StWait: begin
        w_state_nxt = tlb_update_i ? StIssue : StOut;
      end
      StOut: begin
        if (resp_ready_i) w_state_nxt = w_accept ? StIssue : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (flush_i) w_state_nxt = StIdle;
  end

  // ---------------------------------------------------------------------------------------
  // Translation (evaluated every cycle, captured only in WAIT)
  // ---------------------------------------------------------------------------------------
  logic        w_is_fetch;
  logic        w_is_store;
  logic        w_dmw0_hit;
  logic        w_dmw1_hit;
  logic [31:0] w_paddr;
  logic [1:0]  w_mat;
  logic [2:0]  w_ecode;
  logic [IDX_W-1:0] w_index;

  assign w_is_fetch = (r_type == TypeFetch);
  assign w_is_store = (r_type == TypeStore);

  // A window is enabled only for PLV0 or PLV3; PLV1/2 never hit a DMW.
  assign w_dmw0_hit = (csr_dmw0_i[31:29] == r_vaddr[31:29]) &&
                      (((csr_plv_i == 2'd0) && csr_dmw0_i[0]) ||
                       ((csr_plv_i == 2'd3) && csr_dmw0_i[3]));
  assign w_dmw1_hit = (csr_dmw1_i[31:29] == r_vaddr[31:29]) &&
                      (((csr_plv_i == 2'd0) && csr_dmw1_i[0]) ||
                       ((csr_plv_i == 2'd3) && csr_dmw1_i[3]));

  always_comb begin
    w_paddr = 32'd0;
    w_mat   = 2'd0;
    w_ecode = EcNone;
    w_index = '0;
    if (csr_da_i) begin
      w_paddr = r_vaddr;
      w_mat   = w_is_fetch ? csr_datf_i : csr_datm_i;
    end else if (w_dmw0_hit) begin
      w_paddr = {csr_dmw0_i[27:25], r_vaddr[28:0]};
      w_mat   = csr_dmw0_i[5:4];
    end else if (w_dmw1_hit) begin
      w_paddr = {csr_dmw1_i[27:25], r_vaddr[28:0]};
      w_mat   = csr_dmw1_i[5:4];
    end else begin
      if (w_tlb_found) w_index = w_tlb_index;
      if (!w_tlb_found) begin
        w_ecode = EcTlbr;
      end else if (!w_tlb_v) begin
        w_ecode = w_is_fetch ? EcPif : (w_is_store ? EcPis : EcPil);
      end else if (csr_plv_i > w_tlb_plv) begin
        w_ecode = EcPpi;
      end else if (w_is_store && !w_tlb_d) begin
        w_ecode = EcPme;
      end else begin
        w_mat = w_tlb_mat;
        // Any page size other than 4 MiB is resolved as a 4 KiB page.
        if (w_tlb_ps == 6'd22) begin
          w_paddr = {w_tlb_ppn[19:10], r_vaddr[21:0]};
        end else begin
          w_paddr = {w_tlb_ppn[19:0], r_vaddr[11:0]};
        end
      end
    end
  end

  // DMW fields that the translation does not use.
  logic w_unused;
  assign w_unused = ^{csr_dmw0_i[28], csr_dmw0_i[24:6], csr_dmw0_i[2:1],
                      csr_dmw1_i[28], csr_dmw1_i[24:6], csr_dmw1_i[2:1]};

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_vaddr      <= 32'd0;
      r_type       <= 2'd0;
      r_paddr      <= 32'd0;
      r_mat        <= 2'd0;
      r_ecode      <= EcNone;
      r_index      <= '0;
      r_replay_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_vaddr <= req_vaddr_i;
        r_type  <= req_type_i;
      end
      if (w_capture) begin
        r_paddr <= w_paddr;
        r_mat   <= w_mat;
        r_ecode <= w_ecode;
        r_index <= w_index;
      end
      if (w_replay && (r_replay_cnt != 8'hFF)) begin
        r_replay_cnt <= r_replay_cnt + 8'd1;
      end
    end
  end

  assign lookup_vaddr_o   = r_vaddr;
  assign resp_valid_o     = (r_state == StOut);
  assign resp_paddr_o     = r_paddr;
  assign resp_mat_o       = r_mat;
  assign resp_ecode_o     = r_ecode;
  assign resp_tlb_index_o = r_index;
  assign replay_cnt_o     = r_replay_cnt;

endmodule

// File: tb/tb_mmu_addr_trans.sv
// Directed bench for mmu_addr_trans: a vector table of translation cases plus hand-written
// sequences for replay, back-pressure, flush and asynchronous reset.

module tb_mmu_addr_trans;

  localparam int RESP_W = 1 + 5 + 6 + 20 + 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [31:0]       req_vaddr_i;
  logic [1:0]        req_type_i;
  logic [31:0]       lookup_vaddr_o;
  logic [RESP_W-1:0] tlb_s_resp_i;
  logic              tlb_update_i;
  logic              flush_i;
  logic              csr_da_i;
  logic [1:0]        csr_plv_i;
  logic [1:0]        csr_datf_i;
  logic [1:0]        csr_datm_i;
  logic [31:0]       csr_dmw0_i;
  logic [31:0]       csr_dmw1_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [31:0]       resp_paddr_o;
  logic [1:0]        resp_mat_o;
  logic [2:0]        resp_ecode_o;
  logic [4:0]        resp_tlb_index_o;
  logic [7:0]        replay_cnt_o;

  mmu_addr_trans #(
    .PPN_W         (20),
    .TLB_ENTRY_NUM (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_vaddr_i      (req_vaddr_i),
    .req_type_i       (req_type_i),
    .lookup_vaddr_o   (lookup_vaddr_o),
    .tlb_s_resp_i     (tlb_s_resp_i),
    .tlb_update_i     (tlb_update_i),
    .flush_i          (flush_i),
    .csr_da_i         (csr_da_i),
    .csr_plv_i        (csr_plv_i),
    .csr_datf_i       (csr_datf_i),
    .csr_datm_i       (csr_datm_i),
    .csr_dmw0_i       (csr_dmw0_i),
    .csr_dmw1_i       (csr_dmw1_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_paddr_o     (resp_paddr_o),
    .resp_mat_o       (resp_mat_o),
    .resp_ecode_o     (resp_ecode_o),
    .resp_tlb_index_o (resp_tlb_index_o),
    .replay_cnt_o     (replay_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        da;
    logic [1:0]  plv, datf, datm;
    logic [31:0] dmw0, dmw1, vaddr;
    logic [1:0]  typ;
    logic        found;
    logic [4:0]  idx;
    logic [5:0]  ps;
    logic [19:0] ppn;
    logic [1:0]  eplv, emat;
    logic        ed, ev;
    logic [31:0] e_paddr;
    logic [1:0]  e_mat;
    logic [2:0]  e_ecode;
    logic [4:0]  e_idx;
  } vec_t;

  function automatic vec_t mk(
    input logic da, input logic [1:0] plv, input logic [1:0] datf, input logic [1:0] datm,
    input logic [31:0] dmw0, input logic [31:0] dmw1, input logic [31:0] vaddr,
    input logic [1:0] typ, input logic found, input logic [4:0] idx, input logic [5:0] ps,
    input logic [19:0] ppn, input logic [1:0] eplv, input logic [1:0] emat, input logic ed,
    input logic ev, input logic [31:0] e_paddr, input logic [1:0] e_mat,
    input logic [2:0] e_ecode, input logic [4:0] e_idx);
    vec_t v;
    v.da = da; v.plv = plv; v.datf = datf; v.datm = datm;
    v.dmw0 = dmw0; v.dmw1 = dmw1; v.vaddr = vaddr; v.typ = typ;
    v.found = found; v.idx = idx; v.ps = ps; v.ppn = ppn;
    v.eplv = eplv; v.emat = emat; v.ed = ed; v.ev = ev;
    v.e_paddr = e_paddr; v.e_mat = e_mat; v.e_ecode = e_ecode; v.e_idx = e_idx;
    return v;
  endfunction

  task automatic apply_csr_tlb(input vec_t v);
    csr_da_i     = v.da;
    csr_plv_i    = v.plv;
    csr_datf_i   = v.datf;
    csr_datm_i   = v.datm;
    csr_dmw0_i   = v.dmw0;
    csr_dmw1_i   = v.dmw1;
    tlb_s_resp_i = {v.found, v.idx, v.ps, v.ppn, v.eplv, v.emat, v.ed, v.ev};
  endtask

  // Offers a request on a falling edge and returns 1 ns after the accepting rising edge.
  task automatic start_req(input logic [31:0] vaddr, input logic [1:0] typ);
    @(negedge clk);
    req_vaddr_i = vaddr;
    req_type_i  = typ;
    req_valid_i = 1'b1;
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Counts falling edges after the accept edge until resp_valid_o; bounded.
  task automatic wait_valid(input int start, output int n);
    n = start;
    while (!resp_valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid_o) chk("resp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain;
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic chk_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid_o) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  localparam logic [31:0] D0 = 32'hA000_0011;  // vseg 5, pseg 0, plv0, mat 1
  localparam logic [31:0] D1 = 32'hA200_0029;  // vseg 5, pseg 1, plv0+plv3, mat 2

  vec_t vecs[$];
  int   n;
  logic [31:0] hold_paddr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_vaddr_i = '0; req_type_i = '0;
    tlb_s_resp_i = '0; tlb_update_i = 1'b0; flush_i = 1'b0; resp_ready_i = 1'b0;
    csr_da_i = 1'b0; csr_plv_i = '0; csr_datf_i = '0; csr_datm_i = '0;
    csr_dmw0_i = '0; csr_dmw1_i = '0;

    //         da plv datf datm dmw0 dmw1 vaddr         typ f idx ps  ppn       eplv emat d v
    //         exp paddr     mat ec idx
    vecs.push_back(mk(1, 0, 1, 2, D0, D1, 32'h1C00_0100, 0, 0, 0, 12, 20'h0, 0, 0, 0, 0,
                      32'h1C00_0100, 1, 0, 0));
    vecs.push_back(mk(1, 3, 1, 2, D0, D1, 32'h0000_1000, 1, 0, 0, 12, 20'h0, 0, 0, 0, 0,
                      32'h0000_1000, 2, 0, 0));
    vecs.push_back(mk(1, 0, 3, 2, D0, D1, 32'h8000_0010, 2, 1, 5, 12, 20'h11111, 0, 1, 0, 0,
                      32'h8000_0010, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, D0, D1, 32'hA000_1234, 1, 0, 0, 12, 20'h0, 0, 0, 0, 0,
                      32'h0000_1234, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, D0, 0, 32'hA000_1234, 1, 0, 0, 12, 20'h0, 0, 0, 0, 0,
                      32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'hA000_1234, 1, 0, 0, 12, 20'h0, 0, 0, 0, 0,
                      32'h2000_1234, 2, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0040_0ABC, 2, 1, 7, 12, 20'h12345, 3, 1, 0, 1,
                      32'h0, 0, 6, 7));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0040_0ABC, 1, 1, 7, 12, 20'h12345, 3, 1, 0, 1,
                      32'h1234_5ABC, 1, 0, 7));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 1, 1, 12, 22, 20'h80000, 3, 0, 1, 1,
                      32'h8023_4567, 0, 0, 12));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 0, 1, 12, 22, 20'h80000, 3, 0, 1, 0,
                      32'h0, 0, 2, 12));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 2, 1, 12, 22, 20'h80000, 3, 0, 1, 0,
                      32'h0, 0, 4, 12));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 3, 1, 12, 22, 20'h80000, 3, 0, 1, 0,
                      32'h0, 0, 3, 12));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 1, 1, 12, 22, 20'h80000, 0, 0, 1, 1,
                      32'h0, 0, 5, 12));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 1, 0, 9, 22, 20'h80000, 3, 0, 1, 1,
                      32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 2, 1, 12, 22, 20'h80000, 0, 0, 0, 0,
                      32'h0, 0, 4, 12));
    vecs.push_back(mk(0, 3, 0, 0, D0, D1, 32'h0123_4567, 2, 1, 12, 22, 20'h80000, 0, 0, 0, 1,
                      32'h0, 0, 5, 12));
    vecs.push_back(mk(0, 1, 0, 0, D0, D1, 32'hA000_1234, 1, 1, 3, 12, 20'h00ABC, 3, 2, 1, 1,
                      32'h00AB_C234, 2, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, D0, D1, 32'h7FFF_FFFC, 2, 1, 31, 22, 20'hFFC00, 3, 3, 1, 1,
                      32'hFFFF_FFFC, 3, 0, 31));

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_lookup", lookup_vaddr_o, 32'd0);
    chk("rst_paddr", resp_paddr_o, 32'd0);
    chk("rst_cnt", 32'(replay_cnt_o), 32'd0);
    rst_n = 1'b1;

    // Translation table.
    foreach (vecs[i]) begin
      @(negedge clk);
      apply_csr_tlb(vecs[i]);
      start_req(vecs[i].vaddr, vecs[i].typ);
      @(negedge clk);
      chk($sformatf("v%0d_lookup", i), lookup_vaddr_o, vecs[i].vaddr);
      wait_valid(1, n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd3);
      chk($sformatf("v%0d_paddr", i), resp_paddr_o, vecs[i].e_paddr);
      chk($sformatf("v%0d_mat", i), 32'(resp_mat_o), 32'(vecs[i].e_mat));
      chk($sformatf("v%0d_ecode", i), 32'(resp_ecode_o), 32'(vecs[i].e_ecode));
      chk($sformatf("v%0d_index", i), 32'(resp_tlb_index_o), 32'(vecs[i].e_idx));
      drain();
    end

    // Replay from WAIT: response two cycles later, counter +1.
    apply_csr_tlb(vecs[7]);
    start_req(32'h0040_0ABC, 2'd1);
    @(negedge clk);
    @(negedge clk);
    tlb_update_i = 1'b1;
    @(negedge clk);
    tlb_update_i = 1'b0;
    chk("replay_no_early_valid", 32'(resp_valid_o), 32'd0);
    wait_valid(3, n);
    chk("replay_latency", 32'(n), 32'd5);
    chk("replay_cnt_1", 32'(replay_cnt_o), 32'd1);
    chk("replay_paddr", resp_paddr_o, 32'h1234_5ABC);
    drain();

    // Flush together with TLB update in WAIT: flush wins, no count, no response.
    start_req(32'h0040_0ABC, 2'd1);
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    tlb_update_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    tlb_update_i = 1'b0;
    @(negedge clk);
    chk("flushupd_cnt", 32'(replay_cnt_o), 32'd1);
    chk("flushupd_ready", 32'(req_ready_o), 32'd1);
    chk_quiet("flushupd_no_resp", 5);

    // Saturation: hold tlb_update_i through ISSUE for 300 cycles.
    start_req(32'h0040_0ABC, 2'd1);
    @(negedge clk);
    tlb_update_i = 1'b1;
    repeat (100) @(negedge clk);
    chk("replay_cnt_101", 32'(replay_cnt_o), 32'd101);
    repeat (200) @(negedge clk);
    tlb_update_i = 1'b0;
    chk("replay_cnt_sat", 32'(replay_cnt_o), 32'd255);
    wait_valid(0, n);
    chk("sat_paddr", resp_paddr_o, 32'h1234_5ABC);
    chk("replay_cnt_hold", 32'(replay_cnt_o), 32'd255);
    drain();

    // Back-pressure for 4 cycles, then back-to-back accept in OUT.
    start_req(32'h0040_0ABC, 2'd1);
    wait_valid(0, n);
    hold_paddr = resp_paddr_o;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", c), 32'(resp_valid_o), 32'd1);
      chk($sformatf("bp_paddr_%0d", c), resp_paddr_o, 32'h1234_5ABC);
    end
    chk("bp_req_ready_low", 32'(req_ready_o), 32'd0);
    resp_ready_i = 1'b1;
    req_valid_i  = 1'b1;
    req_vaddr_i  = 32'h0040_0123;
    req_type_i   = 2'd1;
    #1;
    chk("b2b_req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    req_valid_i  = 1'b0;
    @(negedge clk);
    chk("b2b_valid_drop", 32'(resp_valid_o), 32'd0);
    wait_valid(1, n);
    chk("b2b_latency", 32'(n), 32'd3);
    chk("b2b_paddr", resp_paddr_o, 32'h1234_5123);

    // Flush in OUT: response discarded, no accept during the flush cycle.
    flush_i      = 1'b1;
    resp_ready_i = 1'b1;
    req_valid_i  = 1'b1;
    #1;
    chk("flush_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i      = 1'b0;
    resp_ready_i = 1'b0;
    req_valid_i  = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(resp_valid_o), 32'd0);
    chk("flush_ready", 32'(req_ready_o), 32'd1);
    chk_quiet("flush_no_resp", 5);

    // Asynchronous reset in ISSUE.
    start_req(32'h0040_0ABC, 2'd1);
    @(negedge clk);
    chk("arst_pre_lookup", lookup_vaddr_o, 32'h0040_0ABC);
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready_o), 32'd1);
    chk("arst_valid", 32'(resp_valid_o), 32'd0);
    chk("arst_lookup", lookup_vaddr_o, 32'd0);
    chk("arst_paddr", resp_paddr_o, 32'd0);
    chk("arst_mat", 32'(resp_mat_o), 32'd0);
    chk("arst_ecode", 32'(resp_ecode_o), 32'd0);
    chk("arst_index", 32'(resp_tlb_index_o), 32'd0);
    chk("arst_cnt", 32'(replay_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_quiet("arst_no_resp", 6);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
